line_clear_engine: RTL and testbench
====================================

LINE_CLEAR_ENGINE -- requirements
Module: line_clear_engine

Interface
REQ-001 SHALL: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL: new_game  in  1  sync pulse; zeroes lines_cleared and goal_reached.
REQ-004 SHALL: start  in  1  one-cycle pulse after piece lock; requests a clear pass.
REQ-005 SHALL: playfield_occ  in  PLAYFIELD_ROWS x PLAYFIELD_COLS  occupancy bitmap; row 0 top, row 19 bottom.
REQ-006 SHALL: busy  out  1  high while a pass is in progress.
REQ-007 SHALL: row_wr_en  out  1  playfield store row-write strobe.
REQ-008 SHALL: row_wr_dst  out  5  destination row index.
REQ-009 SHALL: row_wr_src  out  5  source row index; meaningful when row_wr_clr=0.
REQ-010 SHALL: row_wr_clr  out  1  1 = write destination row empty; 0 = copy src to dst.
REQ-011 SHALL: done  out  1  one-cycle pulse at end of pass.
REQ-012 SHALL: pass_cleared  out  3  rows cleared by last pass (0..4); held until next done.
REQ-013 SHALL: lines_cleared  out  6  running total; feeds the lines-cleared pixel driver.
REQ-014 SHALL: goal_reached  out  1  high when lines_cleared >= LINES_GOAL.

Function
REQ-015 SHALL: FSM states IDLE, SCAN, FILL, DONE; IDLE after reset.
REQ-016 SHALL: in IDLE, start=1 registers playfield_occ into an internal snapshot, sets rd=wr=19, count=0, enters SCAN; busy=1 from the next cycle.
REQ-017 SHALL: start while busy=1 is ignored; no queuing.
REQ-018 SHALL: SCAN processes one row per cycle using snapshot row rd: full (all bits 1) -> count+1, rd-1, no write; not full and rd!=wr -> row_wr_en=1, dst=wr, src=rd, clr=0, then rd-1, wr-1; not full and rd==wr -> no write, rd-1, wr-1.
REQ-019 SHALL: SCAN processes exactly 20 cycles (rd 19..0), then enters FILL if count>0, else DONE.
REQ-020 SHALL: FILL issues row_wr_en=1, clr=1, dst=wr for each remaining wr down to 0 inclusive, one per cycle (count cycles total), then enters DONE.
REQ-021 SHALL: DONE lasts one cycle: done=1, pass_cleared<=count, lines_cleared<=min(lines_cleared+count, 63), busy=0 next cycle, return to IDLE.
REQ-022 SHALL: total latency from start to done = 20 + count + 1 cycles after the start cycle.
REQ-023 SHALL: row writes occur in strictly decreasing dst order; row_wr_en=0 in IDLE and DONE.
REQ-024 SHALL: non-contiguous full rows (e.g. 19 and 17) compact correctly; upper rows shift down by the number of full rows below them.
REQ-025 SHALL: count saturates at 4 for safety; more than 4 full rows is not a legal input.
REQ-026 SHALL: new_game takes priority over DONE's increment in the same cycle (result 0); new_game does not abort a pass in progress.
REQ-027 SHALL: goal_reached is combinational from lines_cleared.

Reset
REQ-028 SHALL: rst forces IDLE, busy=0, row_wr_en=0, dst=src=0, row_wr_clr=0, done=0, pass_cleared=0, lines_cleared=0, goal_reached=0, snapshot cleared; an asserted reset mid-pass abandons it with no further writes.

Structure
REQ-029 SHALL: PLAYFIELD_ROWS (20), PLAYFIELD_COLS (10), LINES_GOAL (40) and the FSM state enum live in GamePkg.
REQ-030 SHALL: implemented as one module with no sub-modules; row-full detection is a per-row AND reduction inside it.

Verification
REQ-031 SHALL: empty playfield, start -> 20 SCAN cycles with no writes, done at cycle 21, pass_cleared=0, lines_cleared unchanged.
REQ-032 SHALL: row 19 full, row 18 has one tile, start -> writes (19<-18), (18<-17) ... (1<-0), then clear dst 0; done at cycle 22; pass_cleared=1.
REQ-033 SHALL: rows 19,18,17,16 full, lines_cleared=38 -> 4 FILL clears dst 3..0, done at cycle 25, lines_cleared=42, goal_reached=1.
REQ-034 SHALL: rows 19 and 17 full, row 18 partial -> first write (19<-18), then (18<-16) ...; pass_cleared=2.
REQ-035 SHALL: second start pulse mid-SCAN -> ignored, exactly one done; new_game coincident with DONE -> lines_cleared=0.
REQ-036 SHALL: rst asserted at SCAN cycle 10 -> all outputs at reset values immediately, no done, lines_cleared=0.

Source files
------------

// File: rtl/line_clear_engine_pkg.sv
// Shared playfield geometry, scoring limits and the line-clear FSM state type.
package GamePkg;

    localparam int unsigned PLAYFIELD_ROWS = 20;
    localparam int unsigned PLAYFIELD_COLS = 10;
    localparam int unsigned LINES_GOAL     = 40;

    localparam int unsigned OCC_W     = PLAYFIELD_ROWS * PLAYFIELD_COLS;
    localparam int unsigned ROW_W     = 5;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned LINES_W   = 6;
    localparam int unsigned LINES_MAX = 63;
    localparam int unsigned MAX_CLEAR = 4;

    // Row-indexed view of the occupancy bitmap; row 0 is the top row.
    typedef logic [PLAYFIELD_ROWS-1:0][PLAYFIELD_COLS-1:0] field_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FILL,
        DONE
    } state_t;

endpackage

// File: rtl/line_clear_engine.sv
// Line clear engine: after a piece locks, scans a snapshot of the playfield
// bottom-up, emits row copy/clear writes that compact away full rows, then
// updates the per-pass and running cleared-line counts.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   new_game            zeroes lines_cleared (and so goal_reached)
//   start               request a clear pass (ignored while busy)
//   playfield_occ       flat occupancy bitmap, row r at bits [r*COLS +: COLS]
//   busy                pass in progress
//   row_wr_en/dst/src/clr  playfield store row-write command
//   done                one-cycle end-of-pass pulse
//   pass_cleared        rows cleared by the last pass
//   lines_cleared       saturating running total
//   goal_reached        lines_cleared has reached LINES_GOAL
module line_clear_engine
    import GamePkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               new_game,
    input  logic               start,
    input  logic [OCC_W-1:0]   playfield_occ,
    output logic               busy,
    output logic               row_wr_en,
    output logic [ROW_W-1:0]   row_wr_dst,
    output logic [ROW_W-1:0]   row_wr_src,
    output logic               row_wr_clr,
    output logic               done,
    output logic [CNT_W-1:0]   pass_cleared,
    output logic [LINES_W-1:0] lines_cleared,
    output logic               goal_reached
);

    localparam int unsigned SUM_W = LINES_W + 1;

    state_t             state, state_n;
    logic [ROW_W-1:0]   rd, rd_n, wr, wr_n;
    logic [CNT_W-1:0]   count, count_n;
    field_t             snap, snap_n;

    logic               busy_n, wr_en_n, wr_clr_n, done_n;
    logic [ROW_W-1:0]   dst_n, src_n;
    logic [SUM_W-1:0]   lines_sum;
    logic [LINES_W-1:0] lines_sat;

    // A row is full when every column is occupied; out-of-range rows never are.
    function automatic logic row_full(input field_t f, input logic [ROW_W-1:0] idx);
        return (idx < ROW_W'(PLAYFIELD_ROWS)) ? &f[idx] : 1'b0;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, scan pointers, and the output values for the coming cycle.
    // Outputs are registered, so they are derived from the next-state values
    // so that each write strobe lines up with the cycle that issues it.
    always_comb begin
        state_n  = state;
        rd_n     = rd;
        wr_n     = wr;
        count_n  = count;
        snap_n   = snap;
        wr_en_n  = 1'b0;
        wr_clr_n = 1'b0;
        dst_n    = '0;
        src_n    = '0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    snap_n  = field_t'(playfield_occ);
                    rd_n    = ROW_W'(PLAYFIELD_ROWS - 1);
                    wr_n    = ROW_W'(PLAYFIELD_ROWS - 1);
                    count_n = '0;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                // Full rows are skipped: rd moves on while wr stays put.
                if (row_full(snap, rd)) begin
                    if (count != CNT_W'(MAX_CLEAR)) begin
                        count_n = count + CNT_W'(1);
                    end
                    rd_n = rd - ROW_W'(1);
                end else begin
                    rd_n = rd - ROW_W'(1);
                    wr_n = wr - ROW_W'(1);
                end
                if (rd == '0) begin
                    state_n = (count_n != '0) ? FILL : DONE;
                end
            end
            FILL: begin
                wr_n = wr - ROW_W'(1);
                if (wr == '0) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);

        unique case (state_n)
            SCAN: begin
                // Only a surviving row that must move produces a copy.
                if (!row_full(snap_n, rd_n) && (rd_n != wr_n)) begin
                    wr_en_n = 1'b1;
                    dst_n   = wr_n;
                    src_n   = rd_n;
                end
            end
            FILL: begin
                wr_en_n  = 1'b1;
                wr_clr_n = 1'b1;
                dst_n    = wr_n;
            end
            default: begin
            end
        endcase
    end

    assign lines_sum = {1'b0, lines_cleared} + SUM_W'(count);
    assign lines_sat = (lines_sum > SUM_W'(LINES_MAX)) ? LINES_W'(LINES_MAX)
                                                       : lines_sum[LINES_W-1:0];

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd            <= '0;
            wr            <= '0;
            count         <= '0;
            snap          <= '0;
            busy          <= 1'b0;
            row_wr_en     <= 1'b0;
            row_wr_dst    <= '0;
            row_wr_src    <= '0;
            row_wr_clr    <= 1'b0;
            done          <= 1'b0;
            pass_cleared  <= '0;
            lines_cleared <= '0;
        end else begin
            rd         <= rd_n;
            wr         <= wr_n;
            count      <= count_n;
            snap       <= snap_n;
            busy       <= busy_n;
            row_wr_en  <= wr_en_n;
            row_wr_dst <= dst_n;
            row_wr_src <= src_n;
            row_wr_clr <= wr_clr_n;
            done       <= done_n;
            if (state == DONE) begin
                pass_cleared <= count;
            end
            // A new game wins over the end-of-pass accumulation.
            if (new_game) begin
                lines_cleared <= '0;
            end else if (state == DONE) begin
                lines_cleared <= lines_sat;
            end
        end
    end

    assign goal_reached = (lines_cleared >= LINES_W'(LINES_GOAL));

endmodule

// File: tb/tb_line_clear_engine.sv
// Self-checking bench for line_clear_engine: a per-cycle expectation queue
// built from the compaction rules, plus hand-computed literal expectations.
module tb_line_clear_engine;
    import GamePkg::*;

    logic               clk;
    logic               rst;
    logic               new_game;
    logic               start;
    logic [OCC_W-1:0]   playfield_occ;
    logic               busy;
    logic               row_wr_en;
    logic [ROW_W-1:0]   row_wr_dst;
    logic [ROW_W-1:0]   row_wr_src;
    logic               row_wr_clr;
    logic               done;
    logic [CNT_W-1:0]   pass_cleared;
    logic [LINES_W-1:0] lines_cleared;
    logic               goal_reached;

    line_clear_engine dut (
        .clk           (clk),
        .rst           (rst),
        .new_game      (new_game),
        .start         (start),
        .playfield_occ (playfield_occ),
        .busy          (busy),
        .row_wr_en     (row_wr_en),
        .row_wr_dst    (row_wr_dst),
        .row_wr_src    (row_wr_src),
        .row_wr_clr    (row_wr_clr),
        .done          (done),
        .pass_cleared  (pass_cleared),
        .lines_cleared (lines_cleared),
        .goal_reached  (goal_reached)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       en;
        logic       clr;
        logic       done;
        logic [4:0] dst;
        logic [4:0] src;
        logic [2:0] pass;
        logic [5:0] lines;
    } exp_t;

    typedef struct {
        string name;
        int    act;
        int    req;
    } lit_t;

    exp_t exp_q[$];
    lit_t lit_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state between passes.
    int   m_pass  = 0;
    int   m_lines = 0;

    // Observations of the most recent pass.
    int   t_done_cycle;
    int   t_done_count;
    int   t_nw;
    int   t_w_dst[2];
    int   t_w_src[2];

    task automatic lit(input string n, input int a, input int r);
        lit_t l;
        l.name = n;
        l.act  = a;
        l.req  = r;
        lit_q.push_back(l);
    endtask

    function automatic bit m_full(input logic [OCC_W-1:0] o, input int r);
        logic [PLAYFIELD_COLS-1:0] b;
        b = o[r*PLAYFIELD_COLS +: PLAYFIELD_COLS];
        return &b;
    endfunction

    function automatic logic [OCC_W-1:0] set_row(input logic [OCC_W-1:0] o, input int r,
                                                 input logic [PLAYFIELD_COLS-1:0] b);
        logic [OCC_W-1:0] x;
        x = o;
        x[r*PLAYFIELD_COLS +: PLAYFIELD_COLS] = b;
        return x;
    endfunction

    function automatic logic [OCC_W-1:0] full_rows(input logic [19:0] mask);
        logic [OCC_W-1:0] x;
        x = '0;
        for (int r = 0; r < 20; r++) begin
            if (mask[r]) x = set_row(x, r, '1);
        end
        return x;
    endfunction

    // Per-cycle comparison against the model queue, plus literal checks.
    always @(negedge clk) begin
        exp_t e;
        lit_t l;
        if (!rst) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e       = '0;
                e.pass  = 3'(m_pass);
                e.lines = 6'(m_lines);
            end
            checks++;
            if (busy !== e.busy || row_wr_en !== e.en || done !== e.done ||
                pass_cleared !== e.pass || lines_cleared !== e.lines ||
                goal_reached !== (e.lines >= 6'd40) ||
                (e.en && (row_wr_dst !== e.dst || row_wr_clr !== e.clr ||
                          (!e.clr && row_wr_src !== e.src)))) begin
                errors++;
                $display("FAIL cycle_check t=%0t act/req busy %b/%b en %b/%b dst %0d/%0d src %0d/%0d clr %b/%b done %b/%b pass %0d/%0d lines %0d/%0d goal %b",
                         $time, busy, e.busy, row_wr_en, e.en, row_wr_dst, e.dst,
                         row_wr_src, e.src, row_wr_clr, e.clr, done, e.done,
                         pass_cleared, e.pass, lines_cleared, e.lines, goal_reached);
            end
        end
        while (lit_q.size() > 0) begin
            l = lit_q.pop_front();
            checks++;
            if (l.act != l.req) begin
                errors++;
                $display("FAIL %s actual %0d required %0d", l.name, l.act, l.req);
            end
        end
    end

    // One clear pass: start in cycle 0, optional extra start / new_game /
    // reset in a given cycle (-1 = none). The model derives every cycle's
    // expected outputs from where each surviving row must end up.
    task automatic run_pass(input logic [OCC_W-1:0] occ, input int extra_start_at,
                            input int ng_at, input int rst_at);
        int   c;
        int   below;
        int   last;
        int   r;
        int   base;
        int   after;
        exp_t e;

        c = 0;
        for (int i = 0; i < 20; i++) if (m_full(occ, i)) c++;
        last = 21 + c;

        @(posedge clk); #1;
        playfield_occ = occ;
        start         = 1'b1;
        for (int k = 0; k <= last; k++) begin
            e       = '0;
            e.pass  = 3'(m_pass);
            e.lines = (ng_at >= 1 && k > ng_at) ? 6'd0 : 6'(m_lines);
            e.busy  = (k >= 1);
            if (k >= 1 && k <= 20) begin
                r = 20 - k;
                if (!m_full(occ, r)) begin
                    below = 0;
                    for (int j = r + 1; j < 20; j++) if (m_full(occ, j)) below++;
                    if (below != 0) begin
                        e.en  = 1'b1;
                        e.dst = 5'(r + below);
                        e.src = 5'(r);
                    end
                end
            end else if (k >= 21 && k <= 20 + c) begin
                e.en  = 1'b1;
                e.clr = 1'b1;
                e.dst = 5'(c - 1 - (k - 21));
            end
            e.done = (k == last);
            exp_q.push_back(e);
        end

        t_done_cycle = -1;
        t_done_count = 0;
        t_nw         = 0;
        for (int k = 0; k <= last; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                start    = (k == extra_start_at);
                new_game = (k == ng_at);
                if (k == rst_at) begin
                    rst = 1'b1;
                    exp_q.delete();
                    m_lines = 0;
                    m_pass  = 0;
                    #1;
                    lit("rst_busy", int'(busy), 0);
                    lit("rst_wr_en", int'(row_wr_en), 0);
                    lit("rst_dst", int'(row_wr_dst), 0);
                    lit("rst_src", int'(row_wr_src), 0);
                    lit("rst_clr", int'(row_wr_clr), 0);
                    lit("rst_done", int'(done), 0);
                    lit("rst_pass", int'(pass_cleared), 0);
                    lit("rst_lines", int'(lines_cleared), 0);
                    lit("rst_goal", int'(goal_reached), 0);
                    @(posedge clk); #1;
                    rst      = 1'b0;
                    start    = 1'b0;
                    new_game = 1'b0;
                    return;
                end
            end
            @(negedge clk);
            if (done) begin
                if (t_done_cycle < 0) t_done_cycle = k;
                t_done_count++;
            end
            if (row_wr_en && t_nw < 2) begin
                t_w_dst[t_nw] = int'(row_wr_dst);
                t_w_src[t_nw] = int'(row_wr_src);
                t_nw++;
            end
        end

        @(posedge clk); #1;
        start    = 1'b0;
        new_game = 1'b0;
        base  = (ng_at >= 1 && ng_at < last) ? 0 : m_lines;
        after = (base + c > 63) ? 63 : base + c;
        if (ng_at == last) after = 0;
        m_pass  = c;
        m_lines = after;
    endtask

    initial begin
        logic [OCC_W-1:0] f;

        rst           = 1'b1;
        start         = 1'b0;
        new_game      = 1'b0;
        playfield_occ = '0;
        repeat (2) @(posedge clk);
        #1;
        lit("reset_busy", int'(busy), 0);
        lit("reset_wr_en", int'(row_wr_en), 0);
        lit("reset_done", int'(done), 0);
        lit("reset_lines", int'(lines_cleared), 0);
        lit("reset_goal", int'(goal_reached), 0);
        rst = 1'b0;

        // Empty playfield: no writes, done at cycle 21.
        run_pass('0, -1, -1, -1);
        lit("empty_done_cycle", t_done_cycle, 21);
        lit("empty_writes", t_nw, 0);
        lit("empty_pass", int'(pass_cleared), 0);
        lit("empty_lines", int'(lines_cleared), 0);

        // Bottom row full, one tile above it.
        f = set_row(full_rows(20'h80000), 18, 10'h001);
        run_pass(f, -1, -1, -1);
        lit("one_done_cycle", t_done_cycle, 22);
        lit("one_first_dst", t_w_dst[0], 19);
        lit("one_first_src", t_w_src[0], 18);
        lit("one_pass", int'(pass_cleared), 1);
        lit("one_lines", int'(lines_cleared), 1);

        // Non-contiguous full rows 19 and 17.
        f = full_rows(20'hA0000);
        f = set_row(f, 18, 10'h155);
        f = set_row(f, 16, 10'h0F0);
        f = set_row(f, 15, 10'h00F);
        run_pass(f, -1, -1, -1);
        lit("gap_done_cycle", t_done_cycle, 23);
        lit("gap_w0_dst", t_w_dst[0], 19);
        lit("gap_w0_src", t_w_src[0], 18);
        lit("gap_w1_dst", t_w_dst[1], 18);
        lit("gap_w1_src", t_w_src[1], 16);
        lit("gap_pass", int'(pass_cleared), 2);
        lit("gap_lines", int'(lines_cleared), 3);

        // Second start mid-SCAN is ignored.
        run_pass(full_rows(20'h80000), 5, -1, -1);
        lit("dbl_start_dones", t_done_count, 1);
        lit("dbl_start_done_cycle", t_done_cycle, 22);
        lit("dbl_start_lines", int'(lines_cleared), 4);

        // new_game mid-pass does not abort the pass.
        run_pass(full_rows(20'h80000), -1, 5, -1);
        lit("ng_mid_dones", t_done_count, 1);
        lit("ng_mid_lines", int'(lines_cleared), 1);

        // new_game coincident with DONE wins.
        run_pass(full_rows(20'hC0000), -1, 23, -1);
        lit("ng_done_lines", int'(lines_cleared), 0);
        lit("ng_done_pass", int'(pass_cleared), 2);

        // Build up to 38, then a tetris crosses the goal.
        for (int i = 0; i < 9; i++) run_pass(full_rows(20'hF0000), -1, -1, -1);
        run_pass(full_rows(20'hC0000), -1, -1, -1);
        lit("pre_goal_lines", int'(lines_cleared), 38);
        lit("pre_goal_goal", int'(goal_reached), 0);
        run_pass(full_rows(20'hF0000), -1, -1, -1);
        lit("tetris_done_cycle", t_done_cycle, 25);
        lit("tetris_lines", int'(lines_cleared), 42);
        lit("tetris_goal", int'(goal_reached), 1);

        // Saturation at 63.
        for (int i = 0; i < 6; i++) run_pass(full_rows(20'hF0000), -1, -1, -1);
        lit("sat_lines", int'(lines_cleared), 63);

        // Reset at SCAN cycle 10 abandons the pass.
        run_pass(full_rows(20'h80000), -1, -1, 10);
        repeat (30) @(posedge clk);
        #1;
        lit("rst_mid_dones", t_done_count, 0);
        lit("rst_mid_lines", int'(lines_cleared), 0);

        // Four scattered full rows with partial rows between them.
        f = full_rows(20'hAA000);
        f = set_row(f, 18, 10'h001);
        f = set_row(f, 16, 10'h002);
        f = set_row(f, 14, 10'h004);
        f = set_row(f, 12, 10'h008);
        for (int r = 0; r < 12; r++) f = set_row(f, r, 10'(r * 37 + 1));
        run_pass(f, -1, -1, -1);
        lit("scatter_done_cycle", t_done_cycle, 25);
        lit("scatter_pass", int'(pass_cleared), 4);
        lit("scatter_lines", int'(lines_cleared), 4);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
